uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 146 ++++++++++++++
 tb/tb_uart_rx.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, mid-bit sampling and stop-bit framing check.
// rx is synchronized; a start bit is only accepted after the line has been seen idle since reset.
//
// state     | meaning
// IDLE      | line idle, waiting for a falling edge on rx_s
// START     | timing to the middle of the start bit to reject glitches
// DATA      | sampling 8 data bits LSB first at mid-bit
// STOP      | sampling the stop bit at mid-bit
// WAIT_IDLE | framing error seen, waiting for the line to return high
module uart_rx #(
   parameter int TICK_DIV   = 326,
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       frame_err,
   output logic       busy
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_IDLE = 3'd4
   } state_t;

   localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
   localparam logic [3:0]  SAMP_LAST = 4'(OVERSAMPLE - 1);
   localparam logic [3:0]  SAMP_MID  = 4'(OVERSAMPLE / 2 - 1);

   state_t      state, next_state;
   logic        rx_m, rx_s;
   logic [1:0]  sync_fill;
   logic        armed;
   logic [15:0] tick_cnt;
   logic [3:0]  samp_cnt;
   logic [2:0]  bit_cnt;
   logic [7:0]  shreg;
   logic        tick, mid_tick, bit_tick;
   logic        start_det, samp_clr, shift_en, load, err;

   assign tick     = (tick_cnt == TICK_LAST);
   assign mid_tick = tick && (samp_cnt == SAMP_MID);
   assign bit_tick = tick && (samp_cnt == SAMP_LAST);
   assign busy     = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      start_det  = 1'b0;
      samp_clr   = 1'b0;
      shift_en   = 1'b0;
      load       = 1'b0;
      err        = 1'b0;
      case (state)
         IDLE: begin
            if (!rx_s && armed) begin
               next_state = START;
               start_det  = 1'b1;
            end
         end
         START: begin
            if (mid_tick) begin
               next_state = rx_s ? IDLE : DATA;
               samp_clr   = 1'b1;
            end
         end
         DATA: begin
            if (bit_tick) begin
               shift_en = 1'b1;
               if (bit_cnt == 3'd7) next_state = STOP;
            end
         end
         STOP: begin
            if (bit_tick) begin
               if (rx_s) begin
                  load       = 1'b1;
                  next_state = IDLE;
               end else begin
                  err        = 1'b1;
                  next_state = WAIT_IDLE;
               end
            end
         end
         WAIT_IDLE: begin
            if (rx_s) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // sync_fill marks when rx_s holds a real line sample rather than its reset value,
   // so a frame already in flight at reset release cannot look like a fresh start edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_m      <= 1'b1;
         rx_s      <= 1'b1;
         sync_fill <= 2'b00;
         armed     <= 1'b0;
      end else begin
         rx_m      <= rx;
         rx_s      <= rx_m;
         sync_fill <= {sync_fill[0], 1'b1};
         armed     <= armed | (sync_fill[1] & rx_s);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tick_cnt  <= 16'd0;
         samp_cnt  <= 4'd0;
         bit_cnt   <= 3'd0;
         shreg     <= 8'h00;
         rx_data   <= 8'h00;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         if (start_det || tick) tick_cnt <= 16'd0;
         else                   tick_cnt <= tick_cnt + 16'd1;

         if (start_det || samp_clr) samp_cnt <= 4'd0;
         else if (tick)             samp_cnt <= samp_cnt + 4'd1;

         if (start_det)     bit_cnt <= 3'd0;
         else if (shift_en) bit_cnt <= bit_cnt + 3'd1;

         if (shift_en) shreg <= {rx_s, shreg[7:1]};
         if (load)     rx_data <= shreg;

         rx_valid  <= load;
         frame_err <= err;
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at TICK_DIV=4 (64 clk per bit): vector table, directed corner cases,
// and random frames checked against a frame-level expectation model.
module tb_uart_rx;

   localparam int BIT = 64;
   localparam logic [1:0] K_VALID = 2'd1;
   localparam logic [1:0] K_ERR   = 2'd2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx  = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid, frame_err, busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int stop_cyc = 0;
   logic       skip_data_chk = 1'b1;
   logic       prev_pulse = 1'b0;
   logic [7:0] prev_data = 8'h00;
   logic [7:0] model_data = 8'h00;

   logic [1:0] ev_kind[$];
   logic [7:0] ev_data[$];
   int         ev_cyc[$];

   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic [1:0] exp_kind;
      logic [7:0] exp_rx_data;
   } vec_t;
   vec_t vecs[6];

   uart_rx #(.TICK_DIV(4), .OVERSAMPLE(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .frame_err (frame_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (rx_valid || frame_err) begin
         check("pulse_exclusive", {31'b0, rx_valid & frame_err}, 32'd0);
         ev_kind.push_back(rx_valid ? K_VALID : K_ERR);
         ev_data.push_back(rx_data);
         ev_cyc.push_back(cyc);
      end
      if (prev_pulse) check("pulse_width", {31'b0, rx_valid | frame_err}, 32'd0);
      if (!skip_data_chk && rx_data !== prev_data)
         check("data_change_with_valid", {31'b0, rx_valid}, 32'd1);
      prev_pulse = rx_valid | frame_err;
      prev_data  = rx_data;
   end

   task automatic send_bit(input logic v);
      rx = v;
      repeat (BIT) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      stop_cyc = cyc;
      send_bit(stop);
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic expect_one(input string tag, input logic [1:0] kind, input logic [7:0] d,
                             input logic chk_lat);
      int lat;
      check({tag, "_count"}, ev_kind.size(), 32'd1);
      if (ev_kind.size() > 0) begin
         check({tag, "_kind"}, {30'b0, ev_kind[0]}, {30'b0, kind});
         if (kind == K_VALID) check({tag, "_data"}, {24'b0, ev_data[0]}, {24'b0, d});
         if (chk_lat) begin
            lat = ev_cyc[0] - stop_cyc;
            checks++;
            if (lat < 32 || lat > 40) begin
               errors++;
               $display("FAIL %s_latency: got %0d cycles into stop bit, expected 32..40", tag, lat);
            end
         end
      end
      ev_kind.delete();
      ev_data.delete();
      ev_cyc.delete();
   endtask

   initial begin
      logic [7:0] d;
      logic       stop;
      int         gap;

      vecs[0] = '{8'hA5, 1'b1, K_VALID, 8'hA5};
      vecs[1] = '{8'h3C, 1'b0, K_ERR,   8'hA5};
      vecs[2] = '{8'h00, 1'b1, K_VALID, 8'h00};
      vecs[3] = '{8'hFF, 1'b1, K_VALID, 8'hFF};
      vecs[4] = '{8'h80, 1'b0, K_ERR,   8'hFF};
      vecs[5] = '{8'h01, 1'b1, K_VALID, 8'h01};

      repeat (3) @(negedge clk);
      check("reset_rx_data", {24'b0, rx_data}, 32'h0);
      check("reset_rx_valid", {31'b0, rx_valid}, 32'd0);
      check("reset_frame_err", {31'b0, frame_err}, 32'd0);
      check("reset_busy", {31'b0, busy}, 32'd0);
      rst = 1'b0;
      idle(10);
      skip_data_chk = 1'b0;

      for (int i = 0; i < 6; i++) begin
         send_frame(vecs[i].data, vecs[i].stop);
         if (!vecs[i].stop) check("wait_idle_busy", {31'b0, busy}, 32'd1);
         expect_one("vec", vecs[i].exp_kind, vecs[i].data, 1'b1);
         idle(20);
         check("vec_rx_data", {24'b0, rx_data}, {24'b0, vecs[i].exp_rx_data});
         check("vec_busy_after", {31'b0, busy}, 32'd0);
      end
      model_data = vecs[5].exp_rx_data;

      // start glitch shorter than half a bit
      rx = 1'b0;
      repeat (20) @(negedge clk);
      idle(100);
      check("glitch_events", ev_kind.size(), 32'd0);
      check("glitch_rx_data", {24'b0, rx_data}, {24'b0, model_data});
      check("glitch_busy", {31'b0, busy}, 32'd0);

      // break: line low for 20 bit times
      rx = 1'b0;
      repeat (20 * BIT) @(negedge clk);
      check("break_busy", {31'b0, busy}, 32'd1);
      expect_one("break", K_ERR, 8'h00, 1'b0);
      idle(10);
      check("break_after_events", ev_kind.size(), 32'd0);
      check("break_after_busy", {31'b0, busy}, 32'd0);
      send_frame(8'h55, 1'b1);
      expect_one("after_break", K_VALID, 8'h55, 1'b1);
      idle(10);
      model_data = 8'h55;

      // back-to-back frames, no idle gap
      send_frame(8'h00, 1'b1);
      expect_one("b2b_first", K_VALID, 8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      expect_one("b2b_second", K_VALID, 8'hFF, 1'b1);
      idle(10);
      check("b2b_rx_data", {24'b0, rx_data}, 32'hFF);

      // reset during data bit 4 of 0x81
      d = 8'h81;
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(d[i]);
      rx = d[4];
      repeat (30) @(negedge clk);
      skip_data_chk = 1'b1;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midreset_rx_data", {24'b0, rx_data}, 32'h0);
      check("midreset_rx_valid", {31'b0, rx_valid}, 32'd0);
      check("midreset_frame_err", {31'b0, frame_err}, 32'd0);
      check("midreset_busy", {31'b0, busy}, 32'd0);
      repeat (BIT - 31) @(negedge clk);
      for (int i = 5; i < 8; i++) send_bit(d[i]);
      send_bit(1'b1);
      idle(20);
      skip_data_chk = 1'b0;
      check("midreset_no_events", ev_kind.size(), 32'd0);
      check("midreset_data_kept", {24'b0, rx_data}, 32'h0);
      send_frame(8'h7E, 1'b1);
      expect_one("post_reset", K_VALID, 8'h7E, 1'b1);
      idle(10);
      check("post_reset_rx_data", {24'b0, rx_data}, 32'h7E);
      model_data = 8'h7E;

      // random frames against the frame-level model
      for (int n = 0; n < 20; n++) begin
         d    = 8'($urandom);
         stop = ($urandom_range(0, 3) != 0);
         send_frame(d, stop);
         if (stop) begin
            model_data = d;
            expect_one("rand", K_VALID, d, 1'b1);
            gap = $urandom_range(0, 40);
         end else begin
            expect_one("rand", K_ERR, d, 1'b1);
            gap = $urandom_range(4, 40);
         end
         check("rand_rx_data", {24'b0, rx_data}, {24'b0, model_data});
         idle(gap);
      end
      idle(20);
      check("final_busy", {31'b0, busy}, 32'd0);
      check("final_rx_data", {24'b0, rx_data}, {24'b0, model_data});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
